cnn_frame_rx: RTL

- Receive-side counterpart of the CNN frame controller. Consumes the vsync/hsync/data run strobes plus pixel data and rebuilds row, col and data_count for each accepted pixel.
- Detects end-of-frame and flags protocol violations: short frame, overrun and premature line break.
- Sits at the output end of the CNN datapath, ahead of the DMA write-back. Also serves as the timing checker in system benches.

---
 rtl/cnn_frame_pkg.sv | 17 +
 rtl/cnn_rx_coord_cnt.sv | 58 +++++
 rtl/cnn_frame_rx.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cnn_frame_pkg.sv
// Shared constants and FSM encoding for the CNN frame receiver.
package cnn_frame_pkg;

  localparam int unsigned W_SIZE_DEF       = 12;
  localparam int unsigned W_FRAME_SIZE_DEF = 2 * W_SIZE_DEF + 1;
  localparam int unsigned W_DATA_DEF       = 8;
  localparam int unsigned W_FCNT_DEF       = 16;
  localparam int unsigned W_CHECKSUM       = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VSYNC  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } rx_state_e;

endpackage

// File: rtl/cnn_rx_coord_cnt.sv
// Column/row/pixel-index counter; col wraps at width-1 and carries into row.
module cnn_rx_coord_cnt
  import cnn_frame_pkg::*;
#(
  parameter int unsigned W_SIZE       = W_SIZE_DEF,
  parameter int unsigned W_FRAME_SIZE = W_FRAME_SIZE_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr_i,
  input  logic                    inc_i,
  input  logic [W_SIZE-1:0]       width_m1_i,
  output logic [W_SIZE-1:0]       col_o,
  output logic [W_SIZE-1:0]       row_o,
  output logic [W_FRAME_SIZE-1:0] count_o
);

  logic [W_SIZE-1:0]       col_q, col_d;
  logic [W_SIZE-1:0]       row_q, row_d;
  logic [W_FRAME_SIZE-1:0] cnt_q, cnt_d;

  // Clear has priority over increment so a restart drops the coincident pixel.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
      cnt_d = '0;
    end else if (inc_i) begin
      if (col_q == width_m1_i) begin
        col_d = '0;
        row_d = row_q + W_SIZE'(1);
      end else begin
        col_d = col_q + W_SIZE'(1);
      end
      cnt_d = cnt_q + W_FRAME_SIZE'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q <= '0;
      row_q <= '0;
      cnt_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      cnt_q <= cnt_d;
    end
  end

  assign col_o   = col_q;
  assign row_o   = row_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/cnn_frame_rx.sv
// Receive-side frame tracker: rebuilds pixel coordinates and flags protocol errors.
// Optional CNN_FRAME_RX_CHECKSUM_EN adds a per-frame 32-bit pixel sum output.
module cnn_frame_rx
  import cnn_frame_pkg::*;
#(
  parameter int unsigned W_SIZE       = W_SIZE_DEF,
  parameter int unsigned W_FRAME_SIZE = 2 * W_SIZE + 1,
  parameter int unsigned W_DATA       = W_DATA_DEF,
  parameter int unsigned W_FCNT       = W_FCNT_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [W_SIZE-1:0]       q_width,
  input  logic [W_SIZE-1:0]       q_height,
  input  logic [W_FRAME_SIZE-1:0] q_frame_size,
  input  logic                    i_vsync_run,
  input  logic                    i_hsync_run,
  input  logic                    i_data_run,
  input  logic [W_DATA-1:0]       i_data,
  output logic                    o_valid,
  output logic [W_DATA-1:0]       o_data,
  output logic [W_SIZE-1:0]       o_row,
  output logic [W_SIZE-1:0]       o_col,
  output logic [W_FRAME_SIZE-1:0] o_data_count,
  output logic                    o_end_frame,
  output logic                    o_busy,
  output logic                    o_err_short,
  output logic                    o_err_overrun,
  output logic                    o_err_line,
  output logic [W_FCNT-1:0]       o_frame_cnt
`ifdef CNN_FRAME_RX_CHECKSUM_EN
  ,
  output logic [W_CHECKSUM-1:0]   o_checksum
`endif
);

  rx_state_e               state_q, state_d;
  logic                    vsync_q;
  logic [W_SIZE-1:0]       width_m1_q, width_m1_d;
  logic [W_SIZE-1:0]       height_m1_q, height_m1_d;
  logic [W_FRAME_SIZE-1:0] last_idx_q, last_idx_d;

  logic                    valid_q, valid_d;
  logic [W_DATA-1:0]       data_q, data_d;
  logic [W_SIZE-1:0]       row_q, row_d;
  logic [W_SIZE-1:0]       col_q, col_d;
  logic [W_FRAME_SIZE-1:0] count_q, count_d;
  logic                    end_q, end_d;
  logic                    busy_q, busy_d;
  logic                    err_short_q, err_short_d;
  logic                    err_overrun_q, err_overrun_d;
  logic                    err_line_q, err_line_d;
  logic [W_FCNT-1:0]       frame_cnt_q, frame_cnt_d;

  logic                    vs_rise;
  logic                    accept;
  logic                    cnt_clr;
  logic [W_SIZE-1:0]       cur_col;
  logic [W_SIZE-1:0]       cur_row;
  logic [W_FRAME_SIZE-1:0] cur_count;

  assign vs_rise = i_vsync_run & ~vsync_q;

  cnn_rx_coord_cnt #(
    .W_SIZE       (W_SIZE),
    .W_FRAME_SIZE (W_FRAME_SIZE)
  ) u_coord_cnt (
    .clk        (clk),
    .rstn       (rstn),
    .clr_i      (cnt_clr),
    .inc_i      (accept),
    .width_m1_i (width_m1_q),
    .col_o      (cur_col),
    .row_o      (cur_row),
    .count_o    (cur_count)
  );

  // Next-state and output decode; a vsync rising edge overrides everything else.
  always_comb begin
    state_d       = state_q;
    width_m1_d    = width_m1_q;
    height_m1_d   = height_m1_q;
    last_idx_d    = last_idx_q;
    valid_d       = 1'b0;
    data_d        = data_q;
    row_d         = row_q;
    col_d         = col_q;
    count_d       = count_q;
    end_d         = 1'b0;
    err_short_d   = err_short_q;
    err_overrun_d = err_overrun_q;
    err_line_d    = err_line_q;
    frame_cnt_d   = frame_cnt_q;
    accept        = 1'b0;
    cnt_clr       = 1'b0;

    if (vs_rise) begin
      state_d     = ST_VSYNC;
      cnt_clr     = 1'b1;
      width_m1_d  = q_width - W_SIZE'(1);
      height_m1_d = q_height - W_SIZE'(1);
      last_idx_d  = (q_frame_size == '0) ? '0 : q_frame_size - W_FRAME_SIZE'(1);
      if (state_q == ST_ACTIVE) begin
        err_short_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (i_data_run) begin
            err_overrun_d = 1'b1;
          end
        end
        ST_VSYNC, ST_ACTIVE: begin
          if ((state_q == ST_ACTIVE) && i_hsync_run && (cur_col != '0)) begin
            err_line_d = 1'b1;
          end
          if (i_data_run) begin
            accept  = 1'b1;
            valid_d = 1'b1;
            data_d  = i_data;
            row_d   = cur_row;
            col_d   = cur_col;
            count_d = cur_count;
            state_d = ST_ACTIVE;
            if (cur_count == last_idx_q) begin
              state_d     = ST_DONE;
              end_d       = 1'b1;
              frame_cnt_d = frame_cnt_q + W_FCNT'(1);
              if ((cur_row != height_m1_q) || (cur_col != width_m1_q)) begin
                err_line_d = 1'b1;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_VSYNC) || (state_d == ST_ACTIVE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      vsync_q       <= 1'b0;
      width_m1_q    <= '0;
      height_m1_q   <= '0;
      last_idx_q    <= '0;
      valid_q       <= 1'b0;
      data_q        <= '0;
      row_q         <= '0;
      col_q         <= '0;
      count_q       <= '0;
      end_q         <= 1'b0;
      busy_q        <= 1'b0;
      err_short_q   <= 1'b0;
      err_overrun_q <= 1'b0;
      err_line_q    <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      vsync_q       <= i_vsync_run;
      width_m1_q    <= width_m1_d;
      height_m1_q   <= height_m1_d;
      last_idx_q    <= last_idx_d;
      valid_q       <= valid_d;
      data_q        <= data_d;
      row_q         <= row_d;
      col_q         <= col_d;
      count_q       <= count_d;
      end_q         <= end_d;
      busy_q        <= busy_d;
      err_short_q   <= err_short_d;
      err_overrun_q <= err_overrun_d;
      err_line_q    <= err_line_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

`ifdef CNN_FRAME_RX_CHECKSUM_EN
  logic [W_CHECKSUM-1:0] sum_q, sum_d;

  // Running sum; holds after the last pixel until the next frame start clears it.
  always_comb begin
    sum_d = sum_q;
    if (vs_rise) begin
      sum_d = '0;
    end else if (accept) begin
      sum_d = sum_q + W_CHECKSUM'(i_data);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign o_checksum = sum_q;
`endif

  assign o_valid       = valid_q;
  assign o_data        = data_q;
  assign o_row         = row_q;
  assign o_col         = col_q;
  assign o_data_count  = count_q;
  assign o_end_frame   = end_q;
  assign o_busy        = busy_q;
  assign o_err_short   = err_short_q;
  assign o_err_overrun = err_overrun_q;
  assign o_err_line    = err_line_q;
  assign o_frame_cnt   = frame_cnt_q;

endmodule
